// File: rtl/data_mem_responder.sv
// data_mem_responder
// Responder side of the core's data-memory request interface. A word-organised
// synchronous RAM sits behind a small IDLE -> WAIT -> ACK FSM that inserts a
// programmable number of wait states. Each access ends with a one-cycle
// mem_ack pulse, and din, mem_err and busy are all registered.
//
// Optional build macro: MEM_VECTOR_INIT_EN
//   When it is defined, words 0 and 1 (byte addresses 0x0 and 0x4) are flop
//   vector registers. Reset loads them with SINT_VEC and HINT_VEC, and writes
//   to them are dropped but still acknowledged.
//   When it is undefined, those addresses are ordinary RAM words.
//
// Handshake (req/ack):
//   - While IDLE, the block accepts the core's request on any rising edge
//     where mem_req=1. On that edge it captures mem_we, d_addr and dout.
//   - After that edge, the block ignores mem_req, mem_we, d_addr and dout
//     until the access completes. No access is ever aborted.
//   - mem_ack pulses for exactly one cycle, WAIT_CYCLES+1 cycles after the
//     accept edge. din and mem_err are valid in that same cycle.
//   - The ack cycle is itself an IDLE cycle. If mem_req is still high then,
//     the block accepts a new access, so the core drops mem_req on mem_ack
//     when it wants a single access.
//   - busy is high from the cycle after the accept edge through the ack
//     cycle.
// Byte lanes are big-endian (byte 0 = din[31:24]). Only full words are
// transferred; the core merges sub-word writes itself.

module data_mem_responder #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 1
`ifdef MEM_VECTOR_INIT_EN
    ,
    parameter logic [31:0] SINT_VEC    = 32'h0000_0100,
    parameter logic [31:0] HINT_VEC    = 32'h0000_0200
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] dout,
    output logic [31:0] din,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy,
    output logic [1:0]  dbg_state_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // Last value the wait counter reaches before the FSM moves to ACK.
    // When WAIT_CYCLES is 0 the WAIT state is never entered, so the value
    // does not matter in that case.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    // FSM state and wait counter
    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;

    // Request captured on the accept edge
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               oor_q, oor_d;

    // Registered outputs
    logic [31:0]        din_q, din_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;

    // Storage
    logic [31:0]        mem_q [DEPTH];
    logic [31:0]        rd_word;
    logic               ram_we;
    logic               accept;

`ifdef MEM_VECTOR_INIT_EN
    logic [31:0]        sint_q;
    logic [31:0]        hint_q;
    logic               vec_hit;
`endif

    // The RAM only sees whole words, so the byte offset bits are unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^d_addr[1:0];

`ifdef MEM_VECTOR_INIT_EN
    // The vector registers cover word indices 0 and 1.
    assign vec_hit = (idx_q[ADDR_W-1:1] == '0);
`endif

    // Read mux: RAM word, overridden by a vector register when one is hit.
    always_comb begin
        rd_word = mem_q[idx_q];
`ifdef MEM_VECTOR_INIT_EN
        if (vec_hit) begin
            rd_word = idx_q[0] ? hint_q : sint_q;
        end
`endif
    end

    // RAM write enable. Writes happen only in the ACK cycle, only for an
    // in-range address, and never to a vector word.
    always_comb begin
        ram_we = (state_q == S_ACK) && we_q && !oor_q;
`ifdef MEM_VECTOR_INIT_EN
        if (vec_hit) begin
            ram_we = 1'b0;
        end
`endif
    end

    // Next-state, wait counter and capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    accept  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Capture the request fields on the accept edge; hold them otherwise
    always_comb begin
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        oor_d   = oor_q;
        if (accept) begin
            idx_d   = d_addr[ADDR_W+1:2];
            we_d    = mem_we;
            wdata_d = dout;
            oor_d   = |d_addr[31:ADDR_W+2];
        end
    end

    // Output next values. The ACK state sets up the values that appear with
    // the mem_ack pulse in the following cycle.
    always_comb begin
        din_d  = din_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        busy_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = mem_req;
            end
            S_WAIT: begin
                busy_d = 1'b1;
            end
            S_ACK: begin
                busy_d = 1'b1;
                ack_d  = 1'b1;
                err_d  = oor_q;
                if (oor_q) begin
                    din_d = 32'h0;
                end else if (we_q) begin
                    din_d = wdata_q;
                end else begin
                    din_d = rd_word;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // FSM state and wait counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Captured request registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            oor_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            oor_q   <= oor_d;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            din_q  <= 32'h0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            din_q  <= din_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
            busy_q <= busy_d;
        end
    end

    // RAM array. Reset does not clear it, but a reset in the ACK cycle
    // cancels that cycle's write.
    always_ff @(posedge clk) begin
        if (rst_n && ram_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_VECTOR_INIT_EN
    // Vector registers: loaded on reset and read-only afterwards
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sint_q <= SINT_VEC;
            hint_q <= HINT_VEC;
        end
    end
`endif

    assign din         = din_q;
    assign mem_ack     = ack_q;
    assign mem_err     = err_q;
    assign busy        = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder.
// Two instances share one clock and reset: u_dut0 with WAIT_CYCLES=0 and
// u_dut1 with WAIT_CYCLES=1.
// Each access pushes its predicted {mem_err, din} onto that instance's
// expected queue. A negedge monitor pops the queue on every mem_ack and
// compares. Build with MEM_VECTOR_INIT_EN defined to also exercise the
// vector registers.

module tb_data_mem_responder;

    localparam int W0 = 0;
    localparam int W1 = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] din   [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];
    logic [1:0]  st    [2];

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q [2][$];
    logic [31:0] model [int];

    // Clock
    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req[0]), .mem_we(we[0]),
        .d_addr(addr[0]), .dout(wdata[0]), .din(din[0]), .mem_ack(ack[0]),
        .mem_err(err[0]), .busy(busy[0]), .dbg_state_o(st[0])
    );

    data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req(req[1]), .mem_we(we[1]),
        .d_addr(addr[1]), .dout(wdata[1]), .din(din[1]), .mem_ack(ack[1]),
        .mem_err(err[1]), .busy(busy[1]), .dbg_state_o(st[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Reference model: predicts {mem_err, din} for one access and updates the RAM image
    function automatic logic [32:0] predict(input int d, input bit w,
                                            input logic [31:0] a, input logic [31:0] wd);
        int k;
        k = d * 4096 + int'(a[13:2]);
        if (|a[31:14]) return {1'b1, 32'h0};
`ifdef MEM_VECTOR_INIT_EN
        if (a[13:3] == '0) return w ? {1'b0, wd} : {1'b0, (a[2] ? 32'h0000_0200 : 32'h0000_0100)};
`endif
        if (w) begin
            model[k] = wd;
            return {1'b0, wd};
        end
        return {1'b0, (model.exists(k) ? model[k] : 32'h0)};
    endfunction

    // Driver: one single access; mem_req is dropped right after the accept edge
    task automatic access(input int d, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, input string tag);
        int lat;
        bit got;
        exp_q[d].push_back(predict(d, w, a, wd));
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        req[d]   = 1'b0;
        we[d]    = 1'($urandom_range(0, 1));
        addr[d]  = $urandom;
        wdata[d] = $urandom;
        check({tag, "_busy_after_accept"}, 32'(busy[d]), 32'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            got = (ack[d] === 1'b1);
        end
        check({tag, "_latency"}, 32'(lat), 32'((d == 1) ? W1 + 1 : W0 + 1));
        check({tag, "_busy_in_ack"}, 32'(busy[d]), 32'd1);
    endtask

    // Scoreboard monitor: every mem_ack consumes one expected entry
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i] === 1'b1) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("dut%0d_spurious_ack", i), 32'(ack[i]), 32'd0);
                end else begin
                    logic [32:0] e;
                    e = exp_q[i].pop_front();
                    check($sformatf("dut%0d_din", i), din[i], e[31:0]);
                    check($sformatf("dut%0d_err", i), 32'(err[i]), 32'(e[32]));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rd;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = 32'h0; wdata[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_din", i), din[i], 32'h0);
            check($sformatf("rst%0d_ack", i), 32'(ack[i]), 32'd0);
            check($sformatf("rst%0d_err", i), 32'(err[i]), 32'd0);
            check($sformatf("rst%0d_busy", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst%0d_state", i), 32'(st[i]), 32'd0);
        end
        rst_n = 1'b1;

`ifdef MEM_VECTOR_INIT_EN
        access(1, 1'b0, 32'h0, 32'h0, "vec_rd_sint");
        access(1, 1'b0, 32'h4, 32'h0, "vec_rd_hint");
        access(1, 1'b1, 32'h4, 32'hFFFF_FFFF, "vec_wr_hint");
        access(1, 1'b0, 32'h4, 32'h0, "vec_rd_hint_again");
`endif

        // Write then read with ignored byte-offset bits (one wait state)
        access(1, 1'b1, 32'h40, 32'hDEAD_BEEF, "wr40");
        access(1, 1'b0, 32'h43, 32'h0, "rd43");

        // Out-of-range read and write; word 0 must be unchanged afterwards
        access(1, 1'b1, 32'h0, 32'h0BAD_F00D, "wr0");
        access(1, 1'b0, 32'h0000_4000, 32'h0, "oor_rd");
        access(1, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, "oor_wr");
        access(1, 1'b0, 32'h0, 32'h0, "rd0_after_oor");

        // Top word of the address space, plus a high-bit out-of-range read
        access(1, 1'b1, 32'h0000_3FFC, 32'hCAFE_0001, "wr_top");
        access(1, 1'b0, 32'h0000_3FFF, 32'h0, "rd_top");
        access(1, 1'b0, 32'h8000_3FFC, 32'h0, "oor_hi_rd");

        // mem_req was dropped after the accept edge: no second access follows
        @(posedge clk); #1;
        check("single_no_reaccept_busy", 32'(busy[1]), 32'd0);
        check("single_no_reaccept_state", 32'(st[1]), 32'd0);

        // Reset during WAIT of a write aborts it with no ack and no RAM write
        access(1, 1'b1, 32'h20, 32'hAAAA_5555, "wr20_prior");
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1234_5678;
        @(posedge clk); #1;
        req[1] = 1'b0;
        check("abort_in_wait_state", 32'(st[1]), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 32'(busy[1]), 32'd0);
        check("abort_ack", 32'(ack[1]), 32'd0);
        check("abort_state", 32'(st[1]), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_late_ack", 32'(ack[1]), 32'd0);
        access(1, 1'b0, 32'h20, 32'h0, "rd20_after_abort");

        // Zero wait states: preload, then hold mem_req for three back-to-back reads
        access(0, 1'b1, 32'h10, 32'd1, "pre10");
        access(0, 1'b1, 32'h14, 32'd2, "pre14");
        access(0, 1'b1, 32'h18, 32'd3, "pre18");
        exp_q[0].push_back(predict(0, 1'b0, 32'h10, 32'h0));
        exp_q[0].push_back(predict(0, 1'b0, 32'h14, 32'h0));
        exp_q[0].push_back(predict(0, 1'b0, 32'h18, 32'h0));
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
        @(posedge clk); #1;
        addr[0] = 32'h14;
        check("b2b_c1_ack", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        check("b2b_c2_ack", 32'(ack[0]), 32'd1);
        @(posedge clk); #1;
        addr[0] = 32'h18;
        check("b2b_c3_ack", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        check("b2b_c4_ack", 32'(ack[0]), 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        check("b2b_c5_ack", 32'(ack[0]), 32'd0);
        @(posedge clk); #1;
        check("b2b_c6_ack", 32'(ack[0]), 32'd1);
        @(posedge clk); #1;
        check("b2b_c7_ack", 32'(ack[0]), 32'd0);
        check("b2b_c7_busy", 32'(busy[0]), 32'd0);

        // Random in-range write/read pairs on both instances
        for (int n = 0; n < 6; n++) begin
            ra = {18'h0, 12'($urandom_range(2, 4095)), 2'($urandom_range(0, 3))};
            rd = $urandom;
            access(n % 2, 1'b1, ra, rd, $sformatf("rnd_wr%0d", n));
            access(n % 2, 1'b0, ra, 32'h0, $sformatf("rnd_rd%0d", n));
        end

        repeat (4) @(posedge clk);
        #1;
        check("dut0_exp_q_drained", 32'(exp_q[0].size()), 32'd0);
        check("dut1_exp_q_drained", 32'(exp_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
